uart_tx_fifo: RTL and testbench

Transmit holding stage that sits directly upstream of uart_transmitter. It buffers bytes written by the APB register block to THR and presents the head byte on tx_data. It drives thre, and pops one entry on each tsr_load from the transmitter. It supports 16550-style FIFO mode (DEPTH entries) and 16450 mode (single holding register), and produces TEMT and the THRE-interrupt event.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_sync_fifo_mem.sv | 20 ++
 rtl/uart_tx_fifo.sv | 73 +++++++
 tb/tb_uart_tx_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART sizing constants and helpers
package uart_pkg;
   localparam int UART_TX_FIFO_DEPTH = 16;
   localparam int UART_DATA_WIDTH    = 8;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/uart_sync_fifo_mem.sv
// uart_sync_fifo_mem: FIFO storage array with one write port and a combinational read port
module uart_sync_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_TX_FIFO_DEPTH,
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                      pclk,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]     rdata
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge pclk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: THR/TX FIFO ahead of uart_transmitter, producing THRE, TEMT and THRE-interrupt events
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_TX_FIFO_DEPTH,
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    utrst,
   input  logic                    fifo_en,
   input  logic                    thr_wr,
   input  logic [DATA_WIDTH-1:0]   thr_wdata,
   input  logic                    tsr_load,
   input  logic                    shift_cnt_eq,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    thre,
   output logic                    temt,
   output logic                    thre_evt,
   output logic                    tx_ovf,
   output logic [ptr_w(DEPTH):0]   tx_level
);
   localparam int AW = ptr_w(DEPTH);
   localparam int LW = AW + 1;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d, cap;
   logic fifo_en_q, tsr_busy_q, tsr_busy_d, thre_evt_q, thre_evt_d, tx_ovf_q, tx_ovf_d;
   logic empty, full, clr, pop, wr_ok;
   logic [DATA_WIDTH-1:0] rdata;
   uart_sync_fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
      .pclk(pclk), .we(wr_ok), .waddr(wr_ptr_q), .wdata(thr_wdata), .raddr(rd_ptr_q), .rdata(rdata)
   );
   // A mode change flushes the queue exactly like an FCR TX reset.
   always_comb begin
      cap        = fifo_en_q ? LW'(DEPTH) : LW'(1);
      empty      = count_q == '0;
      full       = count_q == cap;
      clr        = utrst | (fifo_en ^ fifo_en_q);
      pop        = tsr_load & ~empty & ~clr;
      wr_ok      = thr_wr & (~full | tsr_load) & ~clr;
      wr_ptr_d   = clr ? '0 : wr_ptr_q + AW'(wr_ok);
      rd_ptr_d   = clr ? '0 : rd_ptr_q + AW'(pop);
      count_d    = clr ? '0 : count_q + LW'(wr_ok) - LW'(pop);
      tsr_busy_d = (tsr_load & ~empty) | (tsr_busy_q & ~(shift_cnt_eq & ~tsr_load));
      thre_evt_d = pop & ~wr_ok & (count_q == LW'(1));
      tx_ovf_d   = thr_wr & full & ~tsr_load & ~clr;
   end
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         fifo_en_q  <= 1'b0;
         tsr_busy_q <= 1'b0;
         thre_evt_q <= 1'b0;
         tx_ovf_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         fifo_en_q  <= fifo_en;
         tsr_busy_q <= tsr_busy_d;
         thre_evt_q <= thre_evt_d;
         tx_ovf_q   <= tx_ovf_d;
      end
   end
   assign tx_data  = empty ? '0 : rdata;
   assign thre     = empty;
   assign temt     = empty & ~tsr_busy_q;
   assign thre_evt = thre_evt_q;
   assign tx_ovf   = tx_ovf_q;
   assign tx_level = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-model checker plus directed vectors for uart_tx_fifo
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   logic pclk = 1'b0, presetn = 1'b1, utrst = 1'b0, fifo_en = 1'b1, thr_wr = 1'b0;
   logic tsr_load = 1'b0, shift_cnt_eq = 1'b0;
   logic [7:0] thr_wdata = 8'h00, tx_data;
   logic thre, temt, thre_evt, tx_ovf;
   logic [4:0] tx_level;
   int checks = 0, errors = 0;
   bit go = 0;
   logic [7:0] mq[$];
   bit m_en, m_busy, m_evt, m_ovf, m_clr, m_ld, m_acc;
   int m_n;
   uart_tx_fifo dut (
      .pclk(pclk), .presetn(presetn), .utrst(utrst), .fifo_en(fifo_en), .thr_wr(thr_wr),
      .thr_wdata(thr_wdata), .tsr_load(tsr_load), .shift_cnt_eq(shift_cnt_eq), .tx_data(tx_data),
      .thre(thre), .temt(temt), .thre_evt(thre_evt), .tx_ovf(tx_ovf), .tx_level(tx_level)
   );
   always #5 pclk = ~pclk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // Model: a byte queue bounded by the current mode's capacity.
   always @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         mq.delete();
         m_en = 0; m_busy = 0; m_evt = 0; m_ovf = 0;
      end else begin
         m_n   = mq.size();
         m_clr = utrst || (fifo_en != m_en);
         m_ld  = tsr_load && m_n > 0;
         if (tsr_load) begin
            if (m_n > 0) m_busy = 1;
         end else if (shift_cnt_eq) m_busy = 0;
         m_evt = 0; m_ovf = 0;
         if (m_clr) mq.delete();
         else begin
            m_acc = thr_wr && (m_n < (m_en ? DEPTH : 1) || m_ld);
            if (m_ld) void'(mq.pop_front());
            if (m_acc) mq.push_back(thr_wdata);
            m_ovf = thr_wr && !m_acc;
            m_evt = m_ld && m_n == 1 && !m_acc;
         end
         m_en = fifo_en;
      end
   end
   always @(negedge pclk) begin
      if (go) begin
         chk("tx_level", tx_level, mq.size());
         chk("thre", thre, mq.size() == 0);
         chk("temt", temt, mq.size() == 0 && !m_busy);
         chk("tx_data", tx_data, mq.size() > 0 ? mq[0] : 8'h00);
         chk("thre_evt", thre_evt, m_evt);
         chk("tx_ovf", tx_ovf, m_ovf);
      end
   end
   task automatic wr(input logic [7:0] b);
      thr_wr = 1; thr_wdata = b;
      @(negedge pclk);
      thr_wr = 0;
   endtask
   task automatic pop();
      tsr_load = 1;
      @(negedge pclk);
      tsr_load = 0;
   endtask
   task automatic shift_done();
      shift_cnt_eq = 1;
      @(negedge pclk);
      shift_cnt_eq = 0;
   endtask
   initial begin
      #2 presetn = 0;
      go = 1;
      repeat (2) @(negedge pclk);
      chk("rst_thre", thre, 1);
      chk("rst_temt", temt, 1);
      chk("rst_level", tx_level, 0);
      chk("rst_data", tx_data, 0);
      presetn = 1;
      repeat (2) @(negedge pclk);
      // 1: basic ordering
      wr(8'hA5);
      chk("t1_data", tx_data, 8'hA5);
      chk("t1_thre", thre, 0);
      wr(8'h3C); wr(8'h7E);
      chk("t1_level", tx_level, 3);
      pop(); chk("t1_pop1", tx_data, 8'h3C);
      pop(); chk("t1_pop2", tx_data, 8'h7E);
      pop(); chk("t1_evt", thre_evt, 1);
      @(negedge pclk); chk("t1_evt_off", thre_evt, 0);
      // 2: fill, overflow, wrap
      for (int i = 0; i < 17; i++) begin
         wr(8'(i));
         if (i == 15) chk("t2_full", tx_level, 16);
      end
      chk("t2_ovf", tx_ovf, 1);
      @(negedge pclk); chk("t2_ovf_off", tx_ovf, 0);
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain", tx_data, 8'(i));
         pop();
      end
      for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         chk("t2_wrap", tx_data, 8'hF0 + 8'(i));
         pop();
      end
      // 3: write + pop while full
      for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i));
      thr_wr = 1; thr_wdata = 8'h55; tsr_load = 1;
      @(negedge pclk);
      thr_wr = 0; tsr_load = 0;
      chk("t3_level", tx_level, 16);
      chk("t3_ovf", tx_ovf, 0);
      for (int i = 1; i < 16; i++) begin
         chk("t3_drain", tx_data, 8'h80 + 8'(i));
         pop();
      end
      chk("t3_last", tx_data, 8'h55);
      pop();
      // 4: 16450 mode and mode-change flush
      fifo_en = 0;
      @(negedge pclk);
      wr(8'h11); wr(8'h22);
      chk("t4_ovf", tx_ovf, 1);
      chk("t4_data", tx_data, 8'h11);
      fifo_en = 1;
      @(negedge pclk);
      chk("t4_thre", thre, 1);
      chk("t4_evt", thre_evt, 0);
      @(negedge pclk);
      // 5: utrst with a same-cycle write
      shift_done();
      for (int i = 1; i <= 5; i++) wr(8'(i));
      pop();
      wr(8'h06);
      chk("t5_level", tx_level, 5);
      utrst = 1; thr_wr = 1; thr_wdata = 8'h77;
      @(negedge pclk);
      utrst = 0; thr_wr = 0;
      chk("t5_clr", tx_level, 0);
      chk("t5_temt_busy", temt, 0);
      shift_done();
      chk("t5_temt", temt, 1);
      // 6: TEMT follows the shift register
      wr(8'h99);
      pop();
      chk("t6_thre", thre, 1);
      chk("t6_temt0", temt, 0);
      shift_done();
      chk("t6_temt1", temt, 1);
      repeat (2) @(negedge pclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
